// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and address width.
package i2c_pkg;
   localparam int   I2C_ADDR_W = 7;
   localparam logic ACK        = 1'b0;
   localparam logic NACK       = 1'b1;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      PTR_RX    = 4'd3,
      PTR_ACK   = 4'd4,
      WR_RX     = 4'd5,
      WR_ACK    = 4'd6,
      TX        = 4'd7,
      MACK      = 4'd8,
      WAIT_STOP = 4'd9
   } i2c_state_t;
endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and emits registered one-cycle SCL edge and START/STOP pulses.
module i2c_bus_monitor (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);
   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_hist_q, sda_hist_q;

   // Sync flops reset to the idle-high bus level so reset release never fakes a START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         scl_rise_o <= 1'b0;
         scl_fall_o <= 1'b0;
         start_o    <= 1'b0;
         stop_o     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
         scl_rise_o <=  scl_sync_q[1] & ~scl_hist_q;
         scl_fall_o <= ~scl_sync_q[1] &  scl_hist_q;
         start_o    <=  scl_sync_q[1] &  scl_hist_q & ~sda_sync_q[1] &  sda_hist_q;
         stop_o     <=  scl_sync_q[1] &  scl_hist_q &  sda_sync_q[1] & ~sda_hist_q;
      end
   end

   // SDA level aligned with the registered edge pulses.
   assign sda_o = sda_hist_q;
endmodule

// File: rtl/i2c_regmap_slave.sv
// I2C target exposing a NUM_REGS byte register map with pointer writes, data writes and
// auto-incrementing reads served from a snapshot taken at the read address ACK.
//
// state     | meaning
// IDLE      | bus free or not addressed
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for our address
// PTR_RX    | receiving register pointer byte
// PTR_ACK   | driving ACK for pointer byte
// WR_RX     | receiving a data byte
// WR_ACK    | driving ACK for data byte
// TX        | shifting out shadow[pointer]
// MACK      | sampling master ACK/NACK
// WAIT_STOP | released, waiting for START/STOP
module i2c_regmap_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] I2C_ADDR = 7'h64,
   parameter int                    NUM_REGS = 4,
   localparam int                   PTR_W    = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic                  sda_out,
   input  logic [8*NUM_REGS-1:0] rd_regs,
   output logic                  wr_valid,
   output logic [PTR_W-1:0]      wr_ptr,
   output logic [7:0]            wr_data,
   output logic                  busy
);
   logic sda_s, scl_rise, scl_fall, start_p, stop_p;

   i2c_bus_monitor u_mon (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl),
      .sda_i     (sda_in),
      .sda_o     (sda_s),
      .scl_rise_o(scl_rise),
      .scl_fall_o(scl_fall),
      .start_o   (start_p),
      .stop_o    (stop_p)
   );

   i2c_state_t       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       shift_q, shift_d, tx_q, tx_d, wdat_q, wdat_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, wp_q, wp_d, ptr_inc;
   logic             oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, wv_q, wv_d;
   logic [7:0]       shadow_q [NUM_REGS];
   logic [7:0]       shadow_d [NUM_REGS];
   logic [7:0]       rd_arr   [NUM_REGS];
   logic [7:0]       rx_byte;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) rd_arr[i] = rd_regs[8*i +: 8];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      ptr_d    = ptr_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      rw_d     = rw_q;
      wv_d     = 1'b0;
      wp_d     = wp_q;
      wdat_d   = wdat_q;
      shadow_d = shadow_q;
      ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
      rx_byte  = {shift_q[6:0], sda_s};

      if (stop_p) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_p) begin
         state_d = ADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            ADDR, PTR_RX, WR_RX: begin
               if (scl_rise && cnt_q < 4'd8) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 4'd1;
                  if (state_q == WR_RX && cnt_q == 4'd7) begin
                     wv_d   = 1'b1;
                     wp_d   = ptr_q;
                     wdat_d = rx_byte;
                     ptr_d  = ptr_inc;
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  case (state_q)
                     ADDR: begin
                        if (shift_q[7:1] == I2C_ADDR) begin
                           state_d = ADDR_ACK;
                           oe_d    = 1'b1;
                           busy_d  = 1'b1;
                           rw_d    = shift_q[0];
                        end else begin
                           state_d = WAIT_STOP;
                        end
                     end
                     PTR_RX: begin
                        // Out-of-range pointer is left un-ACKed and keeps the old pointer.
                        if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
                           state_d = PTR_ACK;
                           oe_d    = 1'b1;
                           ptr_d   = shift_q[PTR_W-1:0];
                        end else begin
                           state_d = WAIT_STOP;
                        end
                     end
                     default: begin
                        state_d = WR_ACK;
                        oe_d    = 1'b1;
                     end
                  endcase
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = '0;
                  if (rw_q) begin
                     shadow_d = rd_arr;
                     tx_d     = rd_arr[ptr_q];
                     oe_d     = ~rd_arr[ptr_q][7];
                     state_d  = TX;
                  end else begin
                     oe_d    = 1'b0;
                     state_d = PTR_RX;
                  end
               end
            end
            PTR_ACK, WR_ACK: begin
               if (scl_fall) begin
                  oe_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = WR_RX;
               end
            end
            TX: begin
               // cnt_q==0 on a fall means the byte was loaded after a master ACK.
               if (scl_rise && cnt_q < 4'd8) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd0) begin
                     oe_d = ~tx_q[7];
                  end else if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     state_d = MACK;
                  end else begin
                     tx_d = {tx_q[6:0], 1'b0};
                     oe_d = ~tx_q[6];
                  end
               end
            end
            MACK: begin
               if (scl_rise) begin
                  ptr_d = ptr_inc;
                  case (sda_s)
                     ACK: begin
                        tx_d    = shadow_q[ptr_inc];
                        cnt_d   = '0;
                        state_d = TX;
                     end
                     NACK: state_d = WAIT_STOP;
                  endcase
               end
            end
            default: oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         tx_q     <= '0;
         ptr_q    <= '0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         rw_q     <= 1'b0;
         wv_q     <= 1'b0;
         wp_q     <= '0;
         wdat_q   <= '0;
         shadow_q <= '{default: '0};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         ptr_q    <= ptr_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         rw_q     <= rw_d;
         wv_q     <= wv_d;
         wp_q     <= wp_d;
         wdat_q   <= wdat_d;
         shadow_q <= shadow_d;
      end
   end

   assign sda_oe   = oe_q;
   assign sda_out  = 1'b0;
   assign busy     = busy_q;
   assign wr_valid = wv_q;
   assign wr_ptr   = wp_q;
   assign wr_data  = wdat_q;
endmodule
